// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI master block.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W      = 8;
  localparam int unsigned SPI_CLK_DIV_MIN = 2;
  localparam int unsigned SPI_CNT_W       = 8;
  localparam int unsigned SPI_BIT_W       = 3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } spi_state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period down-counter: reloads to CLK_DIV-1, holds at 0, flags terminal count.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic tc_c,
  output logic pre_tc_c
);

  localparam logic [SPI_CNT_W-1:0] RELOAD_VAL = SPI_CNT_W'(CLK_DIV - 1);

  logic [SPI_CNT_W-1:0] cnt;

  // Down-count within a state; reload on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= RELOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - SPI_CNT_W'(1);
    end
  end

  assign tc_c     = (cnt == '0);
  assign pre_tc_c = (cnt == SPI_CNT_W'(1));

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one byte out on SDO (MSB first) while sampling one byte on SDI.
// Optional back-to-back framing under a single SS when SPI_MASTER_BURST_EN is defined.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [SPI_BYTE_W-1:0] Tx_Byte,
  output logic                  Busy,
  output logic                  Done,
  output logic [SPI_BYTE_W-1:0] Rx_Byte,
  output logic                  SCK,
  output logic                  SS,
  output logic                  SDO,
  input  logic                  SDI
);

  // The SDI synchroniser needs at least two cycles per half-period.
  localparam int unsigned DIV = (CLK_DIV < SPI_CLK_DIV_MIN) ? SPI_CLK_DIV_MIN : CLK_DIV;

  spi_state_e           state, state_n;
  logic                 tc_c, pre_tc_c, reload_c, burst_go_c;
  logic                 load_c, shift_c;
  logic                 ss_n, sck_n, busy_n, done_n;
  logic [SPI_BIT_W-1:0] bit_cnt;
  logic [SPI_BYTE_W-2:0] tx_rest;
  logic [SPI_BYTE_W-1:0] rx_shift;
  logic                 sdi_meta, sdi_sync;

  spi_sck_gen #(.CLK_DIV(DIV)) u_sck_gen (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .reload   (reload_c),
    .tc_c     (tc_c),
    .pre_tc_c (pre_tc_c)
  );

`ifdef SPI_MASTER_BURST_EN
  assign burst_go_c = Start;
`else
  assign burst_go_c = 1'b0;
`endif

  // Next state and next registered output values.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (Start) state_n = SETUP;
      SETUP:   if (tc_c) state_n = HIGH;
      HIGH:    if (tc_c) state_n = LOW;
      LOW:     if (tc_c) state_n = (bit_cnt == {SPI_BIT_W{1'b1}}) ? HOLD : HIGH;
      HOLD:    if (tc_c) state_n = burst_go_c ? SETUP : IDLE;
      default: state_n = IDLE;
    endcase
    reload_c = (state_n != state);
    load_c   = (state_n == SETUP) && (state != SETUP);
    shift_c  = (state == HIGH) && tc_c;
    ss_n     = (state_n == IDLE);
    sck_n    = (state_n == HIGH);
    busy_n   = (state_n != IDLE);
    done_n   = (state == HOLD) && pre_tc_c;
  end

  // State and bus-control registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      SS    <= 1'b1;
      SCK   <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_n;
      SS    <= ss_n;
      SCK   <= sck_n;
      Busy  <= busy_n;
      Done  <= done_n;
    end
  end

  // Transmit/receive shifters, bit counter and received-byte holding register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tx_rest  <= '0;
      SDO      <= 1'b0;
      rx_shift <= '0;
      Rx_Byte  <= '0;
      bit_cnt  <= '0;
    end else begin
      if (load_c) begin
        SDO     <= Tx_Byte[SPI_BYTE_W-1];
        tx_rest <= Tx_Byte[SPI_BYTE_W-2:0];
      end else if (shift_c) begin
        SDO     <= tx_rest[SPI_BYTE_W-2];
        tx_rest <= {tx_rest[SPI_BYTE_W-3:0], 1'b0};
      end else if (state_n == IDLE) begin
        SDO <= 1'b0;
      end
      if (shift_c) begin
        rx_shift <= {rx_shift[SPI_BYTE_W-2:0], sdi_sync};
      end
      if (done_n) begin
        Rx_Byte <= rx_shift;
      end
      if ((state == LOW) && tc_c) begin
        bit_cnt <= bit_cnt + SPI_BIT_W'(1);
      end
    end
  end

  // Two-flop synchroniser for the asynchronous SDI pin.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sdi_meta <= 1'b0;
      sdi_sync <= 1'b0;
    end else begin
      sdi_meta <= SDI;
      sdi_sync <= sdi_meta;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: CLK_DIV=2 and CLK_DIV=5 instances, a mode-0 slave model,
// and optional SDO->SDI loopback. Honours SPI_MASTER_BURST_EN for framing expectations.
module tb_spi_master;

  logic clk, rst_n, start, sel, loop;
  logic [7:0] tx;
  logic start2, start5, sdi;
  logic busy2, done2, sck2, ss2, sdo2;
  logic busy5, done5, sck5, ss5, sdo5;
  logic [7:0] rx2, rx5;
  logic m_busy, m_done, m_sck, m_ss, m_sdo;
  logic [7:0] m_rx;

  int total = 0;
  int bad   = 0;

  // slave model state
  logic [7:0] slv_tx, slv_out, slv_in;
  int slv_bits;
  logic prev_ss_s, prev_sck_s;
  logic [7:0] slv_q[$];
  logic slv_sdo;

  // measurement results
  int ss_low, pre_high, rises, done_cnt, done_pos, first_rise, busy_low;
  int hi_min, hi_max, lo_min, lo_max, timed_out;
  logic [7:0] sdo_bits;
  logic [7:0] rx_done[2];

  typedef struct {
    logic       loop;
    logic [7:0] tx;
    logic [7:0] slv;
    int         poke;
    logic [7:0] exp_rx;
    logic [7:0] exp_slv;
  } vec_t;
  vec_t vecs[5];

  assign start2  = start && !sel;
  assign start5  = start && sel;
  assign slv_sdo = slv_out[7];
  assign sdi     = loop ? m_sdo : slv_sdo;

  spi_master #(.CLK_DIV(2)) dut2 (
    .Clk(clk), .Rst_n(rst_n), .Start(start2), .Tx_Byte(tx), .Busy(busy2), .Done(done2),
    .Rx_Byte(rx2), .SCK(sck2), .SS(ss2), .SDO(sdo2), .SDI(sdi)
  );

  spi_master #(.CLK_DIV(5)) dut5 (
    .Clk(clk), .Rst_n(rst_n), .Start(start5), .Tx_Byte(tx), .Busy(busy5), .Done(done5),
    .Rx_Byte(rx5), .SCK(sck5), .SS(ss5), .SDO(sdo5), .SDI(sdi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the selected instance to the monitor and slave model.
  always_comb begin
    m_busy = sel ? busy5 : busy2;
    m_done = sel ? done5 : done2;
    m_sck  = sel ? sck5  : sck2;
    m_ss   = sel ? ss5   : ss2;
    m_sdo  = sel ? sdo5  : sdo2;
    m_rx   = sel ? rx5   : rx2;
  end

  // Mode-0 slave: sample SDO on SCK rise, shift out on SCK fall, bit 7 ready at SS fall.
  always @(negedge clk) begin
    if (prev_ss_s && !m_ss) begin
      slv_out  = slv_tx;
      slv_bits = 0;
    end
    if (!m_ss && m_sck && !prev_sck_s) begin
      slv_in = {slv_in[6:0], m_sdo};
      slv_bits++;
      if (slv_bits == 8) begin
        slv_q.push_back(slv_in);
        slv_bits = 0;
      end
    end
    if (!m_ss && !m_sck && prev_sck_s) begin
      if (slv_bits == 0) slv_out = slv_tx;
      else slv_out = {slv_out[6:0], 1'b0};
    end
    prev_ss_s  = m_ss;
    prev_sck_s = m_sck;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Observe one SS-low frame from the current negedge until SS returns high.
  task automatic measure(input int poke_at, input logic [7:0] next_tx, input int drop_after);
    logic prev_sck;
    int run;
    int c;
    ss_low = 0; pre_high = 0; rises = 0; done_cnt = 0; done_pos = 0; first_rise = 0;
    busy_low = 0; hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    sdo_bits = '0; timed_out = 1; prev_sck = 1'b0; run = 0;
    rx_done[0] = '0; rx_done[1] = '0;
    for (c = 0; c < 2000; c++) begin
      if (m_ss) begin
        if (ss_low > 0) begin
          timed_out = 0;
          break;
        end
        pre_high++;
      end else begin
        ss_low++;
        if (!m_busy) busy_low++;
        if (m_sck && !prev_sck) begin
          rises++;
          sdo_bits = {sdo_bits[6:0], m_sdo};
          if (rises == 1) first_rise = ss_low;
        end
        if (m_sck != prev_sck) begin
          if (prev_sck) begin
            if (run < hi_min) hi_min = run;
            if (run > hi_max) hi_max = run;
          end else if (rises > 1) begin
            if (run < lo_min) lo_min = run;
            if (run > lo_max) lo_max = run;
          end
          run = 0;
        end
        run++;
        if (m_done) begin
          done_cnt++;
          if (done_cnt == 1) done_pos = ss_low;
          if (done_cnt <= 2) rx_done[done_cnt-1] = m_rx;
          tx = next_tx;
          if (done_cnt >= drop_after) start = 1'b0;
        end
        if (poke_at >= 0 && ss_low == poke_at) begin
          start = 1'b1;
          tx    = 8'hFF;
        end else if (poke_at >= 0 && ss_low == poke_at + 1) begin
          start = 1'b0;
        end
      end
      prev_sck = m_sck;
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt_r;
    int dcount;
    logic prev;
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; loop = 1'b0; tx = '0; slv_tx = '0;
    slv_out = '0; slv_in = '0; slv_bits = 0; prev_ss_s = 1'b1; prev_sck_s = 1'b0;

    vecs[0] = '{loop: 1'b1, tx: 8'hA5, slv: 8'h00, poke: -1, exp_rx: 8'hA5, exp_slv: 8'hA5};
    vecs[1] = '{loop: 1'b0, tx: 8'hC3, slv: 8'h3C, poke: -1, exp_rx: 8'h3C, exp_slv: 8'hC3};
    vecs[2] = '{loop: 1'b0, tx: 8'h5A, slv: 8'hF0, poke: 10, exp_rx: 8'hF0, exp_slv: 8'h5A};
    vecs[3] = '{loop: 1'b1, tx: 8'h00, slv: 8'hFF, poke: -1, exp_rx: 8'h00, exp_slv: 8'h00};
    vecs[4] = '{loop: 1'b0, tx: 8'hFF, slv: 8'h81, poke: -1, exp_rx: 8'h81, exp_slv: 8'hFF};

    repeat (3) @(negedge clk);
    chk("rst_ss", int'(m_ss), 1);
    chk("rst_sck", int'(m_sck), 0);
    chk("rst_sdo", int'(m_sdo), 0);
    chk("rst_busy", int'(m_busy), 0);
    chk("rst_done", int'(m_done), 0);
    chk("rst_rx", int'(m_rx), 0);
    chk("rst_ss5", int'(ss5), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven single-byte transfers at CLK_DIV=2.
    for (int i = 0; i < 5; i++) begin
      loop = vecs[i].loop; slv_tx = vecs[i].slv; slv_q.delete();
      tx = vecs[i].tx; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      measure(vecs[i].poke, vecs[i].tx, 1);
      chk($sformatf("v%0d_timeout", i), timed_out, 0);
      chk($sformatf("v%0d_ss_fall_lat", i), pre_high, 0);
      chk($sformatf("v%0d_ss_low", i), ss_low, 36);
      chk($sformatf("v%0d_done_pos", i), done_pos, 36);
      chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      chk($sformatf("v%0d_rises", i), rises, 8);
      chk($sformatf("v%0d_first_rise", i), first_rise, 3);
      chk($sformatf("v%0d_sdo_bits", i), int'(sdo_bits), int'(vecs[i].tx));
      chk($sformatf("v%0d_busy_low", i), busy_low, 0);
      chk($sformatf("v%0d_rx_at_done", i), int'(rx_done[0]), int'(vecs[i].exp_rx));
      chk($sformatf("v%0d_rx_held", i), int'(m_rx), int'(vecs[i].exp_rx));
      chk($sformatf("v%0d_slv_cnt", i), slv_q.size(), 1);
      chk($sformatf("v%0d_slv_byte", i), int'(slv_q[0]), int'(vecs[i].exp_slv));
      chk($sformatf("v%0d_hi_len", i), hi_max * 100 + hi_min, 202);
      chk($sformatf("v%0d_lo_len", i), lo_max * 100 + lo_min, 202);
      repeat (2) @(negedge clk);
    end

    // Reset after the 3rd SCK rise.
    loop = 1'b0; slv_tx = 8'h77; slv_q.delete();
    tx = 8'h96; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt_r = 0; prev = 1'b0;
    for (int c = 0; c < 200 && cnt_r < 3; c++) begin
      if (m_sck && !prev) cnt_r++;
      prev = m_sck;
      if (cnt_r < 3) @(negedge clk);
    end
    chk("rstx_reach_rise3", cnt_r, 3);
    rst_n = 1'b0;
    #1;
    chk("rstx_ss", int'(m_ss), 1);
    chk("rstx_sck", int'(m_sck), 0);
    chk("rstx_busy", int'(m_busy), 0);
    chk("rstx_rx", int'(m_rx), 0);
    chk("rstx_sdo", int'(m_sdo), 0);
    dcount = 0;
    repeat (2) begin
      @(negedge clk);
      if (m_done) dcount++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (m_done) dcount++;
    end
    chk("rstx_no_done", dcount, 0);
    chk("rstx_slv_none", slv_q.size(), 0);
    slv_tx = 8'h69;
    tx = 8'h96; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    measure(-1, 8'h96, 1);
    chk("rstx2_ss_low", ss_low, 36);
    chk("rstx2_done_cnt", done_cnt, 1);
    chk("rstx2_rx", int'(rx_done[0]), 8'h69);
    chk("rstx2_slv_byte", int'(slv_q[0]), 8'h96);
    repeat (2) @(negedge clk);

    // CLK_DIV=5 timing.
    sel = 1'b1; loop = 1'b1; slv_q.delete();
    @(negedge clk);
    tx = 8'h3A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    measure(-1, 8'h3A, 1);
    chk("d5_timeout", timed_out, 0);
    chk("d5_ss_low", ss_low, 90);
    chk("d5_done_pos", done_pos, 90);
    chk("d5_first_rise", first_rise, 6);
    chk("d5_rises", rises, 8);
    chk("d5_hi_len", hi_max * 100 + hi_min, 505);
    chk("d5_lo_len", lo_max * 100 + lo_min, 505);
    chk("d5_rx", int'(rx_done[0]), 8'h3A);
    repeat (2) @(negedge clk);
    sel = 1'b0;
    @(negedge clk);

    // Start held across two bytes.
    loop = 1'b0; slv_tx = 8'h00; slv_q.delete();
    tx = 8'h12; start = 1'b1;
    @(negedge clk);
    measure(-1, 8'h34, 2);
`ifdef SPI_MASTER_BURST_EN
    chk("b2b_ss_low", ss_low, 72);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_busy_low", busy_low, 0);
`else
    chk("b2b_ss_low1", ss_low, 36);
    chk("b2b_done_cnt1", done_cnt, 1);
    measure(-1, 8'h34, 1);
    chk("b2b_ss_gap", pre_high, 1);
    chk("b2b_ss_low2", ss_low, 36);
    chk("b2b_done_cnt2", done_cnt, 1);
`endif
    chk("b2b_timeout", timed_out, 0);
    chk("b2b_slv_cnt", slv_q.size(), 2);
    chk("b2b_slv_b0", int'(slv_q[0]), 8'h12);
    chk("b2b_slv_b1", int'(slv_q[1]), 8'h34);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_idle_ss", int'(m_ss), 1);
    chk("b2b_idle_busy", int'(m_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI master (initiator) that drives the bus of the team's SPI slave receiver. It generates SCK and SS from the single system clock and shifts one byte out on SDO, MSB first, while sampling one byte in on SDI. It sits between the host-side control logic and the external SPI pins, using mode 0 (CPOL=0, CPHA=0) so it pairs directly with the slave's SCK-clocked shift register and its SSPIF byte flag.

## Interface
Parameters:
- CLK_DIV, 2: Clk cycles per SCK half-period; legal range 2..255.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst_n  in  1  asynchronous reset, active-low.
- Start  in  1  request a transfer; sampled every Clk.
- Tx_Byte  in  8  byte to send; captured on the accepting Clk.
- Busy  out  1  high from the cycle after acceptance until the return to IDLE.
- Done  out  1  one-Clk pulse; Rx_Byte is valid from this cycle.
- Rx_Byte  out  8  last received byte; held until the next Done.
- SCK  out  1  SPI clock, idle low.
- SS  out  1  slave select, active-low, idle high.
- SDO  out  1  master out; connects to the slave's SDI.
- SDI  in  1  master in, from the slave's SDO; asynchronous to Clk.

## Operation
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD.
- A half-period counter reloads to CLK_DIV-1 on every state entry. A state ends when the counter reaches 0.
- IDLE:
  - Outputs: SS=1, SCK=0, Busy=0.
  - Start=1 latches Tx_Byte into the shift register and moves to SETUP.
- SETUP:
  - SS=0, SDO=bit 7, SCK=0.
  - Lasts CLK_DIV cycles, then HIGH.
- HIGH:
  - SCK=1; the slave samples SDO on this rising edge.
  - On the last cycle of HIGH, shift the synchronised SDI into the Rx shift register LSB.
  - Then LOW.
- LOW:
  - SCK=0; SDO presents the next bit from the first LOW cycle.
  - Bit counter increments.
  - After the 8th LOW, go to HOLD; otherwise go to HIGH.
- HOLD:
  - SS stays 0 and SCK stays 0 for CLK_DIV cycles.
  - On the last HOLD cycle: Done=1 and Rx_Byte updates.
  - Then IDLE.
- SDI path:
  - Passes through a 2-flop synchroniser before sampling.
  - CLK_DIV≥2 guarantees the slave's falling-edge data is stable by the sample point.
- Start while Busy is ignored. Tx_Byte changes after acceptance are ignored.
- Bit counter: 3 bits, wraps 7→0 at HOLD entry.

## Timing
- Reset values (async, immediate): SS=1, SCK=0, SDO=0, Busy=0, Done=0, Rx_Byte=0x00, state IDLE, counters 0, synchroniser 0.
- Reset mid-transfer:
  - Bus returns to idle at once and Done is not pulsed.
  - The partial Rx byte is discarded; Rx_Byte is reset to 0x00.
- Start sampled at edge T:
  - SS falls at T+1.
  - First SCK rise at T+1+CLK_DIV.
- SS is low for exactly 18·CLK_DIV cycles (CLK_DIV=2 → 36).
- Done is asserted in the last low cycle of SS; SS rises on the next edge.
- SCK duty: exactly CLK_DIV high / CLK_DIV low; 8 rising edges per byte.
- Back-to-back, non-burst: Start held continuously gives SS high for exactly 1 cycle between bytes.

## Configuration
- SPI_MASTER_BURST_EN defined:
  - If Start=1 in the Done cycle, load the new Tx_Byte and keep SS low.
  - Go to SETUP on the next edge, with SDO=new bit 7.
  - The slave sees one continuous SS frame.
- SPI_MASTER_BURST_EN undefined:
  - Start in the Done cycle is ignored.
  - SS always deasserts between bytes.

## Structure
- Shared package spi_pkg:
  - state enum (IDLE, SETUP, HIGH, LOW, HOLD)
  - SPI_BYTE_W=8
  - SPI_CLK_DIV_MIN=2
- Sub-module spi_sck_gen: half-period down-counter with reload and terminal-count output, parameterised by CLK_DIV.
- FSM, shift registers and synchroniser stay in spi_master.

## Test plan
- CLK_DIV=2, SDO looped to SDI, Tx 0xA5:
  - Rx_Byte=0xA5.
  - Done exactly 36 cycles after SS falls.
  - 8 SCK rises.
  - SDO bits 1,0,1,0,0,1,0,1.
- Mode-0 slave model returning 0x3C while master sends 0xC3:
  - Slave receives 0xC3.
  - Rx_Byte=0x3C.
- Start pulsed again mid-transfer with Tx 0xFF:
  - Ignored; the first byte completes unchanged.
  - Busy stays high; only one Done.
- Rst_n low after the 3rd SCK rise:
  - Same cycle: SS=1, SCK=0, Busy=0, Rx_Byte=0x00.
  - No Done.
  - Next Start gives a clean transfer.
- CLK_DIV=5:
  - SCK high and low phases exactly 5 cycles each.
  - SS low for exactly 90 cycles.
- With SPI_MASTER_BURST_EN, bytes 0x12 then 0x34:
  - SS low for exactly 72 cycles, never high between bytes.
  - Two Done pulses; the slave reports 0x12 then 0x34.
  - Without the macro: SS high for 1 cycle between bytes.
